// File: rtl/rob_pkg.sv
// Shared types and helpers for the multi-port reorder buffer.
// Default geometry lives here so sub-blocks and the instruction buffer agree on entry layout.
package rob_pkg;

    localparam int unsigned ROB_DEPTH = 16;
    localparam int unsigned ROB_XLEN  = 16;
    localparam int unsigned ROB_RW    = 4;
    localparam int unsigned ROB_IW    = $clog2(ROB_DEPTH);

    typedef struct packed {
        logic                valid;
        logic                done;
        logic [ROB_RW-1:0]   rt;
        logic [ROB_XLEN-1:0] value;
    } rob_entry_t;

    function automatic int unsigned idx_wrap(input int unsigned x, input int unsigned depth);
        return x % depth;
    endfunction

endpackage

// File: rtl/rob_multiport_if.sv
// Dispatch / CDB / flush / commit bundle of the reorder buffer.
// Perf counter outputs appear only when ROB_PERF_CNT_EN is defined.
interface rob_multiport_if #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DISPATCH_W = 4,
    parameter int unsigned CDB_W      = 4,
    parameter int unsigned COMMIT_W   = 4,
    parameter int unsigned XLEN       = 16,
    parameter int unsigned RW         = 4,
    parameter int unsigned IW         = $clog2(DEPTH)
);
    logic [DISPATCH_W-1:0]          disp_valid;
    logic [DISPATCH_W-1:0][RW-1:0]  disp_rt;
    logic                           disp_ready;
    logic [DISPATCH_W-1:0][IW-1:0]  disp_idx;
    logic [CDB_W-1:0]               cdb_valid;
    logic [CDB_W-1:0][IW-1:0]       cdb_idx;
    logic [CDB_W-1:0][XLEN-1:0]     cdb_value;
    logic                           flush_valid;
    logic [IW-1:0]                  flush_idx;
    logic [DEPTH-1:0]               out_done;
    logic [DEPTH-1:0][XLEN-1:0]     out_values;
    logic [COMMIT_W-1:0]            commit_we;
    logic [COMMIT_W-1:0][RW-1:0]    commit_rt;
    logic [COMMIT_W-1:0][XLEN-1:0]  commit_data;
    logic [COMMIT_W-1:0][IW-1:0]    commit_idx;
    logic [IW-1:0]                  head;
    logic [IW:0]                    count;
`ifdef ROB_PERF_CNT_EN
    logic [31:0]                    perf_commits;
    logic [31:0]                    perf_full_cycles;
    logic [15:0]                    perf_flushes;
`endif

    modport master (
        output disp_valid, disp_rt, cdb_valid, cdb_idx, cdb_value, flush_valid, flush_idx,
        input  disp_ready, disp_idx, out_done, out_values,
        input  commit_we, commit_rt, commit_data, commit_idx, head, count
`ifdef ROB_PERF_CNT_EN
        , input perf_commits, perf_full_cycles, perf_flushes
`endif
    );

    modport slave (
        input  disp_valid, disp_rt, cdb_valid, cdb_idx, cdb_value, flush_valid, flush_idx,
        output disp_ready, disp_idx, out_done, out_values,
        output commit_we, commit_rt, commit_data, commit_idx, head, count
`ifdef ROB_PERF_CNT_EN
        , output perf_commits, perf_full_cycles, perf_flushes
`endif
    );

endinterface

// File: rtl/rob_lane_alloc.sv
// Prefix count of per-lane requests: lane k gets the number of requesting lanes below it.
// Shared with the instruction buffer slot allocator.
module rob_lane_alloc #(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = $clog2(N + 1)
) (
    input  logic [N-1:0]          valid,
    output logic [N-1:0][CW-1:0]  offs,
    output logic [CW-1:0]         total
);

    always_comb begin
        total = '0;
        for (int k = 0; k < N; k++) begin
            offs[k] = total;
            total   = total + CW'(valid[k]);
        end
    end

endmodule

// File: rtl/rob_multiport.sv
// Multi-port reorder buffer: DISPATCH_W allocations, CDB_W result writes, COMMIT_W in-order
// retires per cycle, plus mispredict flush. Define ROB_PERF_CNT_EN for saturating perf counters.
module rob_multiport
    import rob_pkg::*;
#(
    parameter int unsigned DEPTH      = ROB_DEPTH,
    parameter int unsigned DISPATCH_W = 4,
    parameter int unsigned CDB_W      = 4,
    parameter int unsigned COMMIT_W   = 4,
    parameter int unsigned XLEN       = ROB_XLEN,
    parameter int unsigned RW         = ROB_RW
) (
    input  logic            clk,
    input  logic            rst_n,
    rob_multiport_if.slave  bus
);

    localparam int unsigned IW  = $clog2(DEPTH);
    localparam int unsigned DCW = $clog2(DISPATCH_W + 1);

    logic [IW-1:0]                  head_q, head_d, tail_q, tail_d;
    logic [IW:0]                    count_q, count_d;
    rob_entry_t                     ent_q [DEPTH];
    rob_entry_t                     ent_d [DEPTH];
    logic [DISPATCH_W-1:0][DCW-1:0] disp_off;
    logic [DCW-1:0]                 disp_tot;
    logic [COMMIT_W-1:0]            cen;
    logic [COMMIT_W-1:0][IW-1:0]    cidx;
    logic [DEPTH-1:0]               sq;
    logic                           flush_act, disp_rdy, disp_fire, run;
    logic [IW-1:0]                  age_f;
    logic [IW:0]                    n_disp, n_commit;

    rob_lane_alloc #(.N(DISPATCH_W), .CW(DCW)) u_alloc (
        .valid (bus.disp_valid),
        .offs  (disp_off),
        .total (disp_tot)
    );

    always_comb begin
        flush_act      = bus.flush_valid && ent_q[bus.flush_idx].valid;
        // ages are measured from head so a full buffer (tail == head) is handled uniformly
        age_f          = bus.flush_idx - head_q;
        disp_rdy       = count_q <= (IW+1)'(DEPTH - DISPATCH_W);
        disp_fire      = disp_rdy && !bus.flush_valid;
        n_disp         = disp_fire ? (IW+1)'(disp_tot) : '0;
        bus.disp_ready = disp_rdy;
        bus.head       = head_q;
        bus.count      = count_q;
        for (int k = 0; k < DISPATCH_W; k++)
            bus.disp_idx[k] = IW'(idx_wrap(32'(tail_q) + 32'(disp_off[k]), DEPTH));

        run      = 1'b1;
        n_commit = '0;
        for (int j = 0; j < COMMIT_W; j++) begin
            cidx[j] = head_q + IW'(j);
            // a flush never retires past the kept branch, even if younger entries are done
            run     = run && ent_q[cidx[j]].valid && ent_q[cidx[j]].done
                          && !(flush_act && (IW'(j) > age_f));
            cen[j]  = run;
            n_commit = n_commit + (IW+1)'(run);
            bus.commit_we[j]   = run;
            bus.commit_rt[j]   = ent_q[cidx[j]].rt;
            bus.commit_data[j] = ent_q[cidx[j]].value;
            bus.commit_idx[j]  = cidx[j];
        end

        for (int i = 0; i < DEPTH; i++) begin
            bus.out_done[i]   = ent_q[i].done;
            bus.out_values[i] = ent_q[i].value;
        end
    end

    always_comb begin
        ent_d = ent_q;
        for (int i = 0; i < DEPTH; i++)
            sq[i] = flush_act && ent_q[i].valid && ((IW'(i) - head_q) > age_f);

        // descending so the lowest channel's write is the one that lands
        for (int c = CDB_W - 1; c >= 0; c--) begin
            if (bus.cdb_valid[c] && ent_q[bus.cdb_idx[c]].valid && !sq[bus.cdb_idx[c]]) begin
                ent_d[bus.cdb_idx[c]].done  = 1'b1;
                ent_d[bus.cdb_idx[c]].value = bus.cdb_value[c];
            end
        end
        for (int j = 0; j < COMMIT_W; j++) begin
            if (cen[j]) begin
                ent_d[cidx[j]].valid = 1'b0;
                ent_d[cidx[j]].done  = 1'b0;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (sq[i]) begin
                ent_d[i].valid = 1'b0;
                ent_d[i].done  = 1'b0;
            end
        end
        if (disp_fire) begin
            for (int k = 0; k < DISPATCH_W; k++)
                if (bus.disp_valid[k])
                    ent_d[bus.disp_idx[k]] = '{valid: 1'b1, done: 1'b0, rt: bus.disp_rt[k], value: '0};
        end

        head_d  = head_q + IW'(n_commit);
        tail_d  = flush_act ? bus.flush_idx + IW'(1) : tail_q + IW'(n_disp);
        count_d = flush_act ? (IW+1)'(age_f) + (IW+1)'(1) - n_commit
                            : count_q + n_disp - n_commit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
        end
    end

`ifdef ROB_PERF_CNT_EN
    logic [31:0] perf_commits_q, perf_commits_d, perf_full_cycles_q, perf_full_cycles_d;
    logic [15:0] perf_flushes_q, perf_flushes_d;

    always_comb begin
        perf_commits_d     = (perf_commits_q > (32'hFFFF_FFFF - 32'(n_commit))) ? '1
                                                                               : perf_commits_q + 32'(n_commit);
        perf_full_cycles_d = perf_full_cycles_q;
        if (count_q == (IW+1)'(DEPTH) && perf_full_cycles_q != '1)
            perf_full_cycles_d = perf_full_cycles_q + 32'd1;
        perf_flushes_d = perf_flushes_q;
        if (flush_act && perf_flushes_q != '1)
            perf_flushes_d = perf_flushes_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_commits_q     <= '0;
            perf_full_cycles_q <= '0;
            perf_flushes_q     <= '0;
        end else begin
            perf_commits_q     <= perf_commits_d;
            perf_full_cycles_q <= perf_full_cycles_d;
            perf_flushes_q     <= perf_flushes_d;
        end
    end

    assign bus.perf_commits     = perf_commits_q;
    assign bus.perf_full_cycles = perf_full_cycles_q;
    assign bus.perf_flushes     = perf_flushes_q;
`endif

endmodule

// File: tb/tb_rob_multiport.sv
// Directed bench for rob_multiport: dispatch, CDB, in-order commit, full/wrap, flush, async reset.
module tb_rob_multiport;

    localparam int unsigned DEPTH = 16, DW = 4, CW = 4, MW = 4, XLEN = 16, RW = 4, IW = 4;

    logic clk, rst_n;
    int   n_chk = 0, n_fail = 0;

    rob_multiport_if #(.DEPTH(DEPTH), .DISPATCH_W(DW), .CDB_W(CW), .COMMIT_W(MW),
                       .XLEN(XLEN), .RW(RW), .IW(IW)) bus ();

    rob_multiport #(.DEPTH(DEPTH), .DISPATCH_W(DW), .CDB_W(CW), .COMMIT_W(MW),
                    .XLEN(XLEN), .RW(RW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.disp_valid  = '0;
        bus.cdb_valid   = '0;
        bus.flush_valid = 1'b0;
    endtask

    task automatic disp(input logic [DW-1:0] v, input int rt0);
        bus.disp_valid = v;
        for (int k = 0; k < DW; k++) bus.disp_rt[k] = RW'(rt0 + k);
    endtask

    task automatic cdb(input int ch, input int idx, input logic [XLEN-1:0] v);
        bus.cdb_valid[ch] = 1'b1;
        bus.cdb_idx[ch]   = IW'(idx);
        bus.cdb_value[ch] = v;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        bus.disp_rt = '0; bus.cdb_idx = '0; bus.cdb_value = '0; bus.flush_idx = '0;
        #3;
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_head", 64'(bus.head), 64'd0);
        chk("rst_ready", 64'(bus.disp_ready), 64'd1);
        chk("rst_we", 64'(bus.commit_we), 64'd0);
        chk("rst_done", 64'(bus.out_done), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        step();

        // four lanes, rt 1..4
        disp(4'b1111, 1); #1;
        chk("disp_idx0", 64'(bus.disp_idx), 64'h3210);
        step(); idle();
        chk("cnt4", 64'(bus.count), 64'd4);
        chk("no_commit", 64'(bus.commit_we), 64'd0);

        // entry 1 completes first, blocked behind entry 0
        cdb(0, 1, 16'h1111); step(); idle(); #1;
        chk("done1", 64'(bus.out_done), 64'h0002);
        chk("blocked", 64'(bus.commit_we), 64'd0);
        cdb(0, 0, 16'h1000); step(); idle(); #1;
        chk("pair_we", 64'(bus.commit_we), 64'b0011);
        chk("pair_d0", 64'(bus.commit_data[0]), 64'h1000);
        chk("pair_d1", 64'(bus.commit_data[1]), 64'h1111);
        chk("pair_rt1", 64'(bus.commit_rt[1]), 64'd2);
        step();
        chk("head2", 64'(bus.head), 64'd2);
        chk("cnt2", 64'(bus.count), 64'd2);

        // sparse lanes take consecutive indices
        disp(4'b1010, 5); #1;
        chk("sparse1", 64'(bus.disp_idx[1]), 64'd4);
        chk("sparse3", 64'(bus.disp_idx[3]), 64'd5);
        step();
        disp(4'b1111, 5); step(); step();
        chk("rdy_at12", 64'(bus.disp_ready), 64'd1);
        step();
        chk("full_cnt", 64'(bus.count), 64'd16);
        chk("full_rdy", 64'(bus.disp_ready), 64'd0);
        step(); idle();
        chk("drop_cnt", 64'(bus.count), 64'd16);
        chk("drop_tail", 64'(bus.disp_idx[0]), 64'd2);
        for (int c = 0; c < 4; c++) cdb(c, 2 + c, XLEN'(16'h200 + c));
        step(); idle(); #1;
        chk("full_we", 64'(bus.commit_we), 64'hF);
        chk("full_rdy2", 64'(bus.disp_ready), 64'd0);
        step();
        chk("head6", 64'(bus.head), 64'd6);
        chk("cnt12", 64'(bus.count), 64'd12);
        chk("rdy_back", 64'(bus.disp_ready), 64'd1);

        // drain 6..13, then wrap-around commit 14,15,0,1,2,3
        for (int c = 0; c < 4; c++) cdb(c, 6 + c, 16'h0);
        step();
        for (int c = 0; c < 4; c++) cdb(c, 10 + c, 16'h0);
        step(); idle(); step();
        chk("head14", 64'(bus.head), 64'd14);
        chk("cnt_w4", 64'(bus.count), 64'd4);
        disp(4'b0011, 7); #1;
        chk("wrap_di1", 64'(bus.disp_idx[1]), 64'd3);
        step(); idle();
        for (int c = 0; c < 4; c++) cdb(c, (14 + c) % 16, XLEN'(16'h100 + ((14 + c) % 16)));
        step(); idle();
        cdb(0, 2, 16'h0102); cdb(1, 3, 16'h0103); #1;
        chk("wrap_we", 64'(bus.commit_we), 64'hF);
        chk("wrap_idx", 64'(bus.commit_idx), 64'h10FE);
        chk("wrap_d2", 64'(bus.commit_data[2]), 64'h0100);
        step(); idle(); #1;
        chk("wrap_we2", 64'(bus.commit_we), 64'b0011);
        chk("wrap_i1", 64'(bus.commit_idx[1]), 64'd3);
        step();
        chk("head4", 64'(bus.head), 64'd4);
        chk("empty", 64'(bus.count), 64'd0);
        chk("empty_we", 64'(bus.commit_we), 64'd0);

        // asynchronous reset with entries live
        disp(4'b1111, 1); step(); idle();
        chk("pre_rst", 64'(bus.count), 64'd4);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_cnt", 64'(bus.count), 64'd0);
        chk("arst_head", 64'(bus.head), 64'd0);
        chk("arst_rdy", 64'(bus.disp_ready), 64'd1);
        @(negedge clk) rst_n = 1'b1;
        step();

        // entries 0..9, duplicate CDB index 2
        disp(4'b1111, 1); step(); step();
        disp(4'b0011, 9); step(); idle();
        chk("cnt10", 64'(bus.count), 64'd10);
        cdb(0, 2, 16'hAAAA); cdb(1, 0, 16'h00A0); cdb(2, 1, 16'h00A1); cdb(3, 2, 16'h5555);
        step(); idle(); #1;
        chk("dup_val", 64'(bus.out_values[2]), 64'hAAAA);
        chk("dup_we", 64'(bus.commit_we), 64'b0111);
        chk("dup_d2", 64'(bus.commit_data[2]), 64'hAAAA);
        step();
        chk("head3", 64'(bus.head), 64'd3);
        chk("cnt7", 64'(bus.count), 64'd7);

        // flush at 5 with 3..9 live, alongside dispatch, CDB to 7 and commit of 3
        cdb(0, 3, 16'h3333); step(); idle();
        bus.flush_valid = 1'b1; bus.flush_idx = 4'd5;
        disp(4'b1111, 1); cdb(0, 7, 16'hBEEF); #1;
        chk("fl_we", 64'(bus.commit_we), 64'b0001);
        chk("fl_d0", 64'(bus.commit_data[0]), 64'h3333);
        step(); idle(); #1;
        chk("fl_cnt", 64'(bus.count), 64'd2);
        chk("fl_head", 64'(bus.head), 64'd4);
        chk("fl_done", 64'(bus.out_done), 64'd0);
        chk("fl_tail", 64'(bus.disp_idx[0]), 64'd6);

        // flush of an invalid index is ignored, dispatch still suppressed
        bus.flush_valid = 1'b1; bus.flush_idx = 4'd12; disp(4'b0001, 1);
        step(); idle(); #1;
        chk("bad_fl_cnt", 64'(bus.count), 64'd2);
        chk("bad_fl_tail", 64'(bus.disp_idx[0]), 64'd6);
        cdb(0, 8, 16'h8888); cdb(1, 5, 16'h5050);
        step(); idle(); #1;
        chk("sq_ignored", 64'(bus.out_done), 64'h0020);
        chk("live_val5", 64'(bus.out_values[5]), 64'h5050);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rob_multiport.md
Name: rob_multiport

Overview:
- Parametrised successor to the fixed 16-entry, 4-wide reorder buffer.
- Tracks in-flight instructions in program order and accepts up to DISPATCH_W allocations per cycle from the instruction buffer.
- Captures results from CDB_W common-data-bus channels and retires up to COMMIT_W completed entries per cycle to the register file.
- New over the previous generation: branch-mispredict flush of younger entries, and a back-pressure `disp_ready` signal, which replaces the ad-hoc size output.

Parameters:
- DEPTH, 16: number of entries; power of two, at least 4.
- DISPATCH_W, 4: dispatch lanes per cycle; must be ≤ DEPTH.
- CDB_W, 4: CDB write channels.
- COMMIT_W, 4: retire lanes per cycle.
- XLEN, 16: result value width.
- RW, 4: architectural register index width.
- IW (derived), $clog2(DEPTH): ROB index width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- disp_valid  in  DISPATCH_W  per-lane allocate request.
- disp_rt  in  DISPATCH_W*RW  destination register per lane.
- disp_ready  out  1  high when free entries ≥ DISPATCH_W.
- disp_idx  out  DISPATCH_W*IW  ROB index granted per lane; combinational.
- cdb_valid  in  CDB_W  result valid per channel.
- cdb_idx  in  CDB_W*IW  ROB index per channel.
- cdb_value  in  CDB_W*XLEN  result value per channel.
- flush_valid  in  1  mispredict squash request.
- flush_idx  in  IW  index of the mispredicted branch; this entry is kept.
- out_done  out  DEPTH  per-entry done flag, for operand forwarding.
- out_values  out  DEPTH*XLEN  per-entry result value.
- commit_we  out  COMMIT_W  register write enable per lane.
- commit_rt  out  COMMIT_W*RW  target register per lane.
- commit_data  out  COMMIT_W*XLEN  write data per lane.
- commit_idx  out  COMMIT_W*IW  ROB index (writer tag) per lane.
- head  out  IW  oldest entry.
- count  out  IW+1  occupied entries.

Behaviour:
- Reset (async, rst_n low):
  - head = tail = 0, count = 0.
  - All entry valid/done bits 0, values 0.
  - commit_we = 0, disp_ready = 1.
- Dispatch:
  - Occurs at a rising edge when disp_ready && !flush_valid.
  - Valid lanes get consecutive indices starting at tail, in lane order; invalid lanes consume no index.
  - disp_idx of lane k = tail + (number of valid lanes below k), mod DEPTH.
  - Each new entry has valid=1, done=0, rt=disp_rt.
  - tail advances by popcount(disp_valid).
  - disp_valid while !disp_ready is dropped; the upstream stage must hold.
- CDB write:
  - At the edge, a channel writes done=1 and value into a valid entry.
  - Writes to invalid entries are ignored.
  - If two channels target the same index, the lowest channel number wins.
  - Results become visible on out_done/out_values in the next cycle.
- Commit (combinational outputs from current state):
  - Lane j is enabled iff entry head+j is valid && done, and all lanes below j are enabled.
  - Commit stops at the first not-done entry.
  - At the edge, committed entries are invalidated and head advances by the committed count.
  - Minimum latency from CDB write to commit_we is 1 cycle.
- Flush (edge):
  - All entries strictly younger than flush_idx, up to tail, are invalidated.
  - tail = flush_idx + 1 mod DEPTH; count is recomputed.
  - Dispatch in the same cycle is discarded.
  - Commit in the same cycle still proceeds, since its entries are older.
  - CDB writes to squashed entries in the same cycle are discarded.
  - Flush with flush_idx not valid is ignored.
- Occupancy:
  - count next = count + dispatched − committed − squashed.
  - Full is count == DEPTH; empty is count == 0.
  - All index arithmetic wraps modulo DEPTH.
  - When full, disp_ready = 0 and no allocation occurs.
  - When empty, commit_we = 0.
- Reset mid-operation immediately clears all state; outputs return to their reset values asynchronously.

Optional Feature:
- Macro: ROB_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_commits (32-bit, total retired instructions), perf_full_cycles (32-bit, cycles with count == DEPTH) and perf_flushes (16-bit).
  - All saturate at their maximum value and reset to 0.
- Undefined: these ports and counters do not exist; core behaviour is identical.

Decomposition:
- Package rob_pkg holds:
  - the rob_entry_t struct (valid, done, rt, value);
  - the idx_wrap function;
  - the localparam IW derivation.
- One sub-module, rob_lane_alloc: combinational prefix-count of disp_valid that produces per-lane offsets and the popcount. It is reused by the instruction buffer's slot allocator.

Test Plan:
- Reset, then dispatch 4 valid lanes with rt=1..4 → disp_idx = 0,1,2,3; count = 4; no commit.
- CDB writes entry 1 then entry 0 on separate cycles → commit lanes 0–1 fire together in the cycle after entry 0 completes; commit_data correct; head = 2.
- Fill to 16 → disp_ready = 0; a further dispatch is dropped and count stays 16; after 4 commits, disp_ready = 1.
- head = 14 with 6 entries, CDB completes all → commits wrap across index 15→0; head = 4.
- Flush with flush_idx = 5 and entries 3–9 live, while dispatching and while CDB writes entry 7 → entries 6–9 invalid; tail = 6; entry 7 not done; dispatch ignored.
- Two CDB channels writing index 2 with 0xAAAA on channel 0 and 0x5555 on channel 3 → out_values[2] = 0xAAAA.
